// File: rtl/load_store_unit.sv
// Memory-access stage: turns execute-stage results into a single req/ready
// transaction on a word-organised data memory and returns extended load data.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  fn3,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  output logic [31:0] load_data,
  output logic        done,
  output logic        err,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam int            CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   load_data_q, load_data_d;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [2:0]    fn3_q;
  logic [1:0]    off_q;
  logic          we_q;

  logic          access, illegal, misal, cap;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;

  function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] o,
                                          input logic [31:0] d);
    logic [31:0] s;
    s = d >> {o, 3'b000};
    case (f)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return d;
    endcase
  endfunction

  always_comb begin
    access  = mem_read | mem_write;
    illegal = (mem_read & mem_write)
            | (mem_read  & ((fn3 == 3'b011) | (fn3[2:1] == 2'b11)))
            | (mem_write & (fn3[2] | (fn3 == 3'b011)));
    misal   = ((fn3[1:0] == 2'b01) & alu_out[0])
            | ((fn3[1:0] == 2'b10) & (alu_out[1:0] != 2'b00));
    case (fn3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << alu_out[1:0];
        wdata_c = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << alu_out[1:0];
        wdata_c = {2{rs2_data[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = rs2_data;
      end
    endcase
  end

  // mem_read/mem_write are not looked at in DONE: the same instruction is
  // still sitting in the pipe and must not be issued a second time.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    load_data_d = load_data_q;
    cap         = 1'b0;
    stall       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (illegal | misal) begin
            err_d = 1'b1;
          end else begin
            cap     = 1'b1;
            stall   = 1'b1;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (dmem_ready) begin
          state_d = DONE;
          if (!we_q) load_data_d = extract(fn3_q, off_q, dmem_rdata);
        end else if ((TIMEOUT > 0) && (cnt_q == TLAST)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      load_data_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      fn3_q       <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
      if (cap) begin
        addr_q  <= {alu_out[31:2], 2'b00};
        wdata_q <= wdata_c;
        be_q    <= be_c;
        fn3_q   <= fn3;
        off_q   <= alu_out[1:0];
        we_q    <= mem_write;
      end
    end
  end

  assign load_data  = load_data_q;
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit (TIMEOUT=4): table of accesses
// plus hand-written reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  fn3;
  logic [31:0] alu_out, rs2_data;
  logic [31:0] load_data;
  logic        done, err, stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .fn3(fn3),
    .alu_out(alu_out), .rs2_data(rs2_data),
    .load_data(load_data), .done(done), .err(err), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  // waits >= 0: ready after that many wait cycles; waits < 0: never ready.
  // exp_err with waits >= 0 means rejected in IDLE; with waits < 0, timeout.
  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  fn3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          waits;
    logic        exp_err;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  n;
    int  stalls;
    logic reject;
    reject = v.exp_err && (v.waits >= 0);
    @(negedge clk);
    mem_read   = v.rd;
    mem_write  = v.wr;
    fn3        = v.fn3;
    alu_out    = v.addr;
    rs2_data   = v.rs2;
    dmem_rdata = v.rdata;
    dmem_ready = 1'b0;
    #1;
    chk({v.name, " accept stall"}, 32'(stall), 32'(!reject));
    stalls = int'(stall);
    if (reject) begin
      @(negedge clk);
      chk({v.name, " err"}, 32'(err), 32'd1);
      chk({v.name, " no req"}, 32'(dmem_req), 32'd0);
      chk({v.name, " no done"}, 32'(done), 32'd0);
      chk({v.name, " ld kept"}, load_data, v.exp_ld);
      idle_inputs();
      @(negedge clk);
      chk({v.name, " err one cycle"}, 32'(err), 32'd0);
      chk({v.name, " still no req"}, 32'(dmem_req), 32'd0);
      return;
    end
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!dmem_req) break;
      n++;
      stalls += int'(stall);
      chk({v.name, " addr"},  dmem_addr, v.exp_addr);
      chk({v.name, " be"},    32'(dmem_be), 32'(v.exp_be));
      chk({v.name, " we"},    32'(dmem_we), 32'(v.exp_we));
      if (v.exp_we) chk({v.name, " wdata"}, dmem_wdata, v.exp_wdata);
      chk({v.name, " done in req"}, 32'(done), 32'd0);
      dmem_ready = (n - 1 == v.waits);
    end
    dmem_ready = 1'b0;
    if (v.waits < 0) begin
      chk({v.name, " req cycles"}, 32'(n), 32'd4);
      chk({v.name, " timeout err"}, 32'(err), 32'd1);
      chk({v.name, " timeout no done"}, 32'(done), 32'd0);
      chk({v.name, " timeout stall"}, 32'(stall), 32'd1);
      chk({v.name, " ld kept"}, load_data, v.exp_ld);
      idle_inputs();
      @(negedge clk);
      chk({v.name, " err one cycle"}, 32'(err), 32'd0);
      chk({v.name, " no done after"}, 32'(done), 32'd0);
    end else begin
      chk({v.name, " req cycles"}, 32'(n), 32'(v.waits + 1));
      chk({v.name, " done"}, 32'(done), 32'd1);
      chk({v.name, " err with done"}, 32'(err), 32'd0);
      chk({v.name, " done stall"}, 32'(stall), 32'd0);
      chk({v.name, " stall cycles"}, 32'(stalls), 32'(v.waits + 2));
      chk({v.name, " load_data"}, load_data, v.exp_ld);
      idle_inputs();
      @(negedge clk);
      chk({v.name, " done one cycle"}, 32'(done), 32'd0);
      chk({v.name, " no reissue"}, 32'(dmem_req), 32'd0);
    end
  endtask

  vec_t vecs[$];
  vec_t sb;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    fn3 = '0; alu_out = '0; rs2_data = '0; dmem_rdata = '0;

    //           name         rd wr fn3     addr      rs2           rdata         wt err we exp_addr  be       wdata         ld
    vecs.push_back('{"LW",    1, 0, 3'b010, 32'h100,  32'h0,        32'hDEADBEEF, 0, 0, 0, 32'h100,  4'b1111, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{"LB",    1, 0, 3'b000, 32'h103,  32'h0,        32'h80112233, 0, 0, 0, 32'h100,  4'b1000, 32'h0,        32'hFFFFFF80});
    vecs.push_back('{"LBU",   1, 0, 3'b100, 32'h103,  32'h0,        32'h80112233, 1, 0, 0, 32'h100,  4'b1000, 32'h0,        32'h00000080});
    vecs.push_back('{"LHU",   1, 0, 3'b101, 32'h102,  32'h0,        32'h80112233, 0, 0, 0, 32'h100,  4'b1100, 32'h0,        32'h00008011});
    vecs.push_back('{"LH",    1, 0, 3'b001, 32'h102,  32'h0,        32'h80112233, 2, 0, 0, 32'h100,  4'b1100, 32'h0,        32'hFFFF8011});
    vecs.push_back('{"SH",    0, 1, 3'b001, 32'h206,  32'h1234ABCD, 32'h55555555, 3, 0, 1, 32'h204,  4'b1100, 32'hABCDABCD, 32'hFFFF8011});
    vecs.push_back('{"SW",    0, 1, 3'b010, 32'h10,   32'hCAFEF00D, 32'h0,        1, 0, 1, 32'h10,   4'b1111, 32'hCAFEF00D, 32'hFFFF8011});
    vecs.push_back('{"LWmis", 1, 0, 3'b010, 32'h101,  32'h0,        32'h0,        0, 1, 0, 32'h0,    4'b0000, 32'h0,        32'hFFFF8011});
    vecs.push_back('{"LHmis", 1, 0, 3'b001, 32'h105,  32'h0,        32'h0,        0, 1, 0, 32'h0,    4'b0000, 32'h0,        32'hFFFF8011});
    vecs.push_back('{"RDWR",  1, 1, 3'b010, 32'h100,  32'h0,        32'h0,        0, 1, 0, 32'h0,    4'b0000, 32'h0,        32'hFFFF8011});
    vecs.push_back('{"LD011", 1, 0, 3'b011, 32'h100,  32'h0,        32'h0,        0, 1, 0, 32'h0,    4'b0000, 32'h0,        32'hFFFF8011});
    vecs.push_back('{"ST100", 0, 1, 3'b100, 32'h100,  32'h0,        32'h0,        0, 1, 0, 32'h0,    4'b0000, 32'h0,        32'hFFFF8011});
    vecs.push_back('{"TMO",   1, 0, 3'b010, 32'h300,  32'h0,        32'h12345678, -1, 1, 0, 32'h300, 4'b1111, 32'h0,        32'hFFFF8011});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst req", 32'(dmem_req), 32'd0);
    chk("rst we", 32'(dmem_we), 32'd0);
    chk("rst load_data", load_data, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset while a load is waiting in REQ
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; fn3 = 3'b010; alu_out = 32'h40;
    @(negedge clk);
    chk("midrst in req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("midrst req", 32'(dmem_req), 32'd0);
    chk("midrst stall", 32'(stall), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    chk("midrst load_data", load_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst quiet", 32'(done | err | dmem_req), 32'd0);

    sb = '{"SB", 0, 1, 3'b000, 32'h3, 32'h5A, 32'h0, 0, 0, 1, 32'h0, 4'b1000, 32'h5A5A5A5A, 32'h0};
    run_vec(sb);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
